hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter LONG_CYCLES, default 3: total Execute-stage occupancy, in cycles, of an instruction with LongE=1; legal range 2..15.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 RA1D, RA2D  input  4 each  Decode-stage source register numbers.
REQ-006 RA1E, RA2E  input  4 each  Execute-stage source register numbers.
REQ-007 WA3E, WA3M, WA3W  input  4 each  destination register numbers in E, M, W.
REQ-008 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enables per stage.
REQ-009 MemToRegE  input  1  Execute-stage instruction is a load.
REQ-010 PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  PC-writing instruction present in the stage.
REQ-011 BranchTakenE  input  1  taken branch resolved in Execute.
REQ-012 LongE  input  1  Execute-stage instruction is a long, multicycle operation.
REQ-013 ForwardAE, ForwardBE  output  2 each  SrcA/SrcB forwarding select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
REQ-014 StallF, StallD, StallE  output  1 each  hold the PC, D, and E pipeline registers (1 = hold).
REQ-015 FlushD, FlushE  output  1 each  clear the D and E pipeline registers to a bubble.
REQ-016 MulBusy  output  1  multicycle FSM is in state BUSY.
REQ-017 StallCount  output  CNT_W  count of cycles in which StallD=1.

Function
REQ-018 ForwardAE SHALL be 10 if RegWriteM & (WA3M==RA1E); otherwise 01 if RegWriteW & (WA3W==RA1E); otherwise 00. The M match SHALL win when both match.
REQ-019 ForwardBE SHALL follow the same rule as ForwardAE, using RA2E.
REQ-020 LDRstall SHALL equal MemToRegE & RegWriteE & ((WA3E==RA1D) | (WA3E==RA2D)).
REQ-021 PCWrPendingF SHALL equal PCSrcD | PCSrcE | PCSrcM.
REQ-022 The FSM SHALL have two states, IDLE and BUSY, and a 4-bit down-counter cnt.
REQ-023 IDLE with LongE=1: MulStall=1 (combinational, same cycle); next state BUSY; cnt loads LONG_CYCLES-2.
REQ-024 BUSY: MulStall=(cnt!=0).
  - cnt!=0: cnt decrements.
  - cnt==0: next state IDLE and the instruction leaves E at that edge.
REQ-025 In BUSY, LongE SHALL NOT restart the FSM, so the held instruction is not re-counted.
REQ-026 With every input quiet except LongE=1, a long instruction SHALL occupy Execute for exactly LONG_CYCLES cycles.
REQ-027 StallF SHALL equal (LDRstall | PCWrPendingF | MulStall) & ~PCSrcW; PCSrcW always releases the PC.
REQ-028 StallD SHALL equal LDRstall | MulStall.
REQ-029 StallE SHALL equal MulStall.
REQ-030 FlushD SHALL equal PCSrcW | BranchTakenE | (PCWrPendingF & ~StallD); a held PC-writing instruction in D is never flushed.
REQ-031 FlushE SHALL equal BranchTakenE | (LDRstall & ~MulStall); no bubble is injected into a held Execute stage.
REQ-032 BranchTakenE SHALL NOT coincide with MulStall or LDRstall; this is guaranteed upstream, and for that combination only BranchTakenE-driven terms are defined.
REQ-033 StallCount SHALL increment by 1 on each rising edge where StallD=1, and SHALL saturate at all-ones with no wrap.
REQ-034 MulBusy SHALL be registered and equal 1 exactly when the state is BUSY.

Reset
REQ-035 reset=0 SHALL asynchronously force state=IDLE, cnt=0, and StallCount=0, so MulBusy=0.
REQ-036 A reset asserted mid-BUSY SHALL abort the operation; after release, MulStall=0 until a new LongE is seen in IDLE.
REQ-037 During reset, the combinational outputs SHALL follow REQ-018..031 with MulStall=0.
REQ-038 With all inputs 0, the outputs SHALL be 0.

Verification
REQ-039 Forwarding priority: RegWriteM=1, WA3M=4, RegWriteW=1, WA3W=4, RA1E=4, RA2E=4 -> ForwardAE=10, ForwardBE=10; clear RegWriteM -> both 01; RA1E=5 -> ForwardAE=00.
REQ-040 Load-use: MemToRegE=1, RegWriteE=1, WA3E=2, RA2D=2 -> StallF=1, StallD=1, FlushE=1, StallE=0; StallCount increments by 1.
REQ-041 Multicycle, LONG_CYCLES=3: LongE=1 held 3 cycles:
  - cycle 0: StallE=1, StallD=1, MulBusy=0.
  - cycle 1: StallE=1, MulBusy=1.
  - cycle 2: StallE=0, MulBusy=1.
  - cycle 3: MulBusy=0.
REQ-042 Multicycle with load-use: the REQ-041 sequence plus the REQ-040 match -> FlushE=0 while StallE=1; FlushE=1 in the first cycle with StallE=0 and the match still present.
REQ-043 PC write: PCSrcD=1 with no stall -> StallF=1, FlushD=1. PCSrcD=1 during MulStall -> FlushD=0. PCSrcW=1 -> StallF=0, FlushD=1.
REQ-044 Reset and saturation:
  - CNT_W=4, StallD held 20 cycles -> StallCount=15.
  - Pulse reset=0 mid-BUSY -> StallCount=0 and MulBusy=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use and
// multicycle stalls, PC-write stall/flush control, and a saturating counter
// of Decode stall cycles.
module hazard_unit #(
    parameter int LONG_CYCLES = 3,   // total Execute occupancy of a long op (2..15)
    parameter int CNT_W       = 16   // stall counter width
) (
    input  logic             clk,
    input  logic             reset,        // async, active low
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemToRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             LongE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {IDLE, BUSY} state_t;

    // The first Execute cycle is spent in IDLE, the rest in BUSY counting
    // down to zero, so the counter starts at LONG_CYCLES-2.
    localparam logic [3:0] CNT_LOAD = 4'(LONG_CYCLES - 2);

    state_t     state, stateNext;
    logic [3:0] cnt, cntNext;
    logic       mulStall;
    logic       ldrStall;
    logic       pcWrPendingF;

    // Forwarding select: the younger result (Memory) wins over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA1E))      ForwardAE = 2'b10;
        else if (RegWriteW && (WA3W == RA1E)) ForwardAE = 2'b01;
        if (RegWriteM && (WA3M == RA2E))      ForwardBE = 2'b10;
        else if (RegWriteW && (WA3W == RA2E)) ForwardBE = 2'b01;
    end

    // Multicycle FSM next state; stall is forced low while reset is held so
    // a LongE seen during reset cannot stall the pipe.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        mulStall  = 1'b0;
        case (state)
            IDLE: begin
                if (LongE) begin
                    mulStall  = 1'b1;
                    stateNext = BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            BUSY: begin
                // LongE is ignored here: it is the same held instruction.
                if (cnt != 4'd0) begin
                    mulStall = 1'b1;
                    cntNext  = cnt - 4'd1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (!reset) mulStall = 1'b0;
    end

    // FSM state and down-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    assign MulBusy = (state == BUSY);

    // Stall and flush decode.
    always_comb begin
        ldrStall     = MemToRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
        pcWrPendingF = PCSrcD | PCSrcE | PCSrcM;
        StallD       = ldrStall | mulStall;
        StallE       = mulStall;
        StallF       = (ldrStall | pcWrPendingF | mulStall) & ~PCSrcW;
        FlushD       = PCSrcW | BranchTakenE | (pcWrPendingF & ~StallD);
        FlushE       = BranchTakenE | (ldrStall & ~mulStall);
    end

    // Saturating count of Decode stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            StallCount <= '0;
        else if (StallD && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + CNT_W'(1);
    end

endmodule
